// File: rtl/mem_arbiter.sv
// Two-requester arbiter for the core's single memory port: IFU vs LSU, one transaction in flight,
// LSU-first priority with a bounded LSU streak so fetch always makes progress.
module mem_arbiter #(
  parameter int MAX_LSU_STREAK = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ifu_req_valid,
  output logic        ifu_req_ready,
  input  logic [31:0] ifu_addr,
  output logic        ifu_resp_valid,
  output logic [31:0] ifu_rdata,
  input  logic        lsu_req_valid,
  output logic        lsu_req_ready,
  input  logic [31:0] lsu_addr,
  input  logic        lsu_wen,
  input  logic [31:0] lsu_wdata,
  input  logic [3:0]  lsu_wmask,
  output logic        lsu_resp_valid,
  output logic [31:0] lsu_rdata,
  output logic        mem_req_valid,
  input  logic        mem_req_ready,
  output logic [31:0] mem_addr,
  output logic        mem_wen,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_rdata,
  output logic        grant_owner
);

  localparam int SW = (MAX_LSU_STREAK < 1) ? 1 : $clog2(MAX_LSU_STREAK + 1);
  localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_LSU_STREAK);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t        state_q, state_d;
  logic [SW-1:0] streak_q, streak_d;
  logic          owner_q, owner_d;
  logic [31:0]   addr_q, addr_d;
  logic          wen_q, wen_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    wmask_q, wmask_d;
  logic          lsu_win;
  logic          any_req;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      streak_q <= '0;
      owner_q  <= 1'b0;
      addr_q   <= '0;
      wen_q    <= 1'b0;
      wdata_q  <= '0;
      wmask_q  <= '0;
    end else begin
      state_q  <= state_d;
      streak_q <= streak_d;
      owner_q  <= owner_d;
      addr_q   <= addr_d;
      wen_q    <= wen_d;
      wdata_q  <= wdata_d;
      wmask_q  <= wmask_d;
    end
  end

  // A tie goes to LSU until the streak limit is reached; a limit of 0 hands every tie to IFU.
  always_comb begin
    lsu_win        = lsu_req_valid && (!ifu_req_valid || (streak_q < STREAK_MAX));
    any_req        = (ifu_req_valid || lsu_req_valid) && !rst;
    state_d        = state_q;
    streak_d       = streak_q;
    owner_d        = owner_q;
    addr_d         = addr_q;
    wen_d          = wen_q;
    wdata_d        = wdata_q;
    wmask_d        = wmask_q;
    ifu_req_ready  = 1'b0;
    lsu_req_ready  = 1'b0;
    mem_req_valid  = 1'b0;
    ifu_resp_valid = 1'b0;
    lsu_resp_valid = 1'b0;
    ifu_rdata      = '0;
    lsu_rdata      = '0;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = REQ;
          owner_d = lsu_win;
          if (lsu_win) begin
            lsu_req_ready = 1'b1;
            addr_d        = lsu_addr;
            wen_d         = lsu_wen;
            wdata_d       = lsu_wdata;
            wmask_d       = lsu_wmask;
            if (ifu_req_valid && (streak_q < STREAK_MAX)) streak_d = streak_q + 1'b1;
          end else begin
            ifu_req_ready = 1'b1;
            addr_d        = ifu_addr;
            wen_d         = 1'b0;
            wdata_d       = '0;
            wmask_d       = 4'hF;
            streak_d      = '0;
          end
        end
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_d = RESP;
      end
      RESP: begin
        ifu_resp_valid = mem_resp_valid && !owner_q;
        lsu_resp_valid = mem_resp_valid && owner_q;
        ifu_rdata      = mem_rdata;
        lsu_rdata      = mem_rdata;
        if (mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr    = addr_q;
  assign mem_wen     = wen_q;
  assign mem_wdata   = wdata_q;
  assign mem_wmask   = wmask_q;
  assign grant_owner = owner_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: cycle vector table, directed reset/starvation sequences,
// and a randomized run against a transaction-level reference model.
module tb_mem_arbiter;
  localparam int MAXS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ifu_req_valid, ifu_req_ready, ifu_resp_valid;
  logic [31:0] ifu_addr, ifu_rdata;
  logic        lsu_req_valid, lsu_req_ready, lsu_wen, lsu_resp_valid;
  logic [31:0] lsu_addr, lsu_wdata, lsu_rdata;
  logic [3:0]  lsu_wmask;
  logic        mem_req_valid, mem_req_ready, mem_wen, mem_resp_valid;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wmask;
  logic        grant_owner;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.MAX_LSU_STREAK(MAXS)) dut (
    .clk(clk), .rst(rst),
    .ifu_req_valid(ifu_req_valid), .ifu_req_ready(ifu_req_ready), .ifu_addr(ifu_addr),
    .ifu_resp_valid(ifu_resp_valid), .ifu_rdata(ifu_rdata),
    .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready), .lsu_addr(lsu_addr),
    .lsu_wen(lsu_wen), .lsu_wdata(lsu_wdata), .lsu_wmask(lsu_wmask),
    .lsu_resp_valid(lsu_resp_valid), .lsu_rdata(lsu_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_addr(mem_addr),
    .mem_wen(mem_wen), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_resp_valid(mem_resp_valid), .mem_rdata(mem_rdata),
    .grant_owner(grant_owner)
  );

  typedef struct {
    logic        iv;
    logic        lv;
    logic        rr;
    logic        rv;
    logic [31:0] rd;
    logic [5:0]  ctl;  // {ifu_rdy, lsu_rdy, mem_req_valid, ifu_resp, lsu_resp, owner}
    int          fld;  // 0 = reset zeros, 1 = IFU fetch fields, 2 = store fields
  } vec_t;

  vec_t vt[15];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [5:0] ctl_now();
    return {ifu_req_ready, lsu_req_ready, mem_req_valid, ifu_resp_valid, lsu_resp_valid, grant_owner};
  endfunction

  function automatic logic [68:0] fld_exp(input int f);
    case (f)
      1:       return {32'h8000_0000, 32'h0, 1'b0, 4'hF};
      2:       return {32'h8000_1000, 32'hDEAD_BEEF, 1'b1, 4'h3};
      default: return '0;
    endcase
  endfunction

  function automatic vec_t mk(input logic iv, input logic lv, input logic rr, input logic rv,
                              input logic [31:0] rd, input logic [5:0] ctl, input int fld);
    vec_t v;
    v.iv = iv; v.lv = lv; v.rr = rr; v.rv = rv; v.rd = rd; v.ctl = ctl; v.fld = fld;
    return v;
  endfunction

  task automatic idle_inputs();
    ifu_req_valid = 0; lsu_req_valid = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_rdata = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    idle_inputs();
    @(posedge clk); #2;
    rst = 1'b0;
  endtask

  // Reference-model state for the randomized phase
  logic        busy, hs, owner_m, resp_now, exp_i, exp_l, acc_i, acc_l;
  int          streak_m, cd;
  logic [68:0] fld_m;
  int          grants[$];
  int          exp_order[10] = '{1, 1, 1, 1, 0, 1, 1, 1, 1, 0};

  initial begin
    rst = 1'b1;
    idle_inputs();
    ifu_addr = 32'h8000_0000; lsu_addr = 32'h8000_1000;
    lsu_wen = 1'b1; lsu_wdata = 32'hDEAD_BEEF; lsu_wmask = 4'h3;

    // Reset state, with a requester already valid
    ifu_req_valid = 1'b1;
    #7;
    chk("reset_ctl", ctl_now(), 6'b0);
    chk("reset_fields", {mem_addr, mem_wdata, mem_wen, mem_wmask}, 69'b0);
    ifu_req_valid = 1'b0;
    @(posedge clk); #2;
    rst = 1'b0;

    vt[0]  = mk(1, 0, 1, 0, 32'h0,   6'b100000, 0);
    vt[1]  = mk(0, 0, 1, 0, 32'h0,   6'b001000, 1);
    vt[2]  = mk(0, 0, 0, 1, 32'h413, 6'b000100, 1);
    vt[3]  = mk(0, 0, 0, 0, 32'h0,   6'b000000, 1);
    vt[4]  = mk(0, 1, 0, 0, 32'h0,   6'b010000, 1);
    vt[5]  = mk(1, 0, 0, 0, 32'h0,   6'b001001, 2);
    vt[6]  = mk(1, 0, 0, 1, 32'h55,  6'b001001, 2);
    vt[7]  = mk(1, 0, 0, 0, 32'h0,   6'b001001, 2);
    vt[8]  = mk(1, 0, 1, 0, 32'h0,   6'b001001, 2);
    vt[9]  = mk(1, 0, 0, 0, 32'h0,   6'b000001, 2);
    vt[10] = mk(1, 0, 0, 1, 32'h0,   6'b000011, 2);
    vt[11] = mk(1, 0, 0, 1, 32'h66,  6'b100001, 2);
    vt[12] = mk(0, 0, 1, 0, 32'h0,   6'b001000, 1);
    vt[13] = mk(0, 0, 0, 1, 32'h13,  6'b000100, 1);
    vt[14] = mk(0, 0, 0, 0, 32'h0,   6'b000000, 1);

    for (int i = 0; i < 15; i++) begin
      ifu_req_valid = vt[i].iv; lsu_req_valid = vt[i].lv;
      mem_req_ready = vt[i].rr; mem_resp_valid = vt[i].rv; mem_rdata = vt[i].rd;
      #3;
      chk($sformatf("vec%0d_ctl", i), ctl_now(), vt[i].ctl);
      chk($sformatf("vec%0d_fields", i), {mem_addr, mem_wdata, mem_wen, mem_wmask}, fld_exp(vt[i].fld));
      if (vt[i].ctl[2]) chk($sformatf("vec%0d_ifu_rdata", i), ifu_rdata, vt[i].rd);
      @(posedge clk); #2;
    end

    // Asynchronous reset while waiting for an LSU response
    idle_inputs();
    lsu_req_valid = 1'b1; mem_req_ready = 1'b1;
    #3 chk("rstmid_lsu_ready", lsu_req_ready, 1'b1);
    @(posedge clk); #2 lsu_req_valid = 1'b0;
    @(posedge clk); #2 mem_req_ready = 1'b0;
    #1 chk("rstmid_owner_before", grant_owner, 1'b1);
    rst = 1'b1; mem_resp_valid = 1'b1; mem_rdata = 32'h1234_5678;
    #1;
    chk("rstmid_ctl", ctl_now(), 6'b0);
    chk("rstmid_fields", {mem_addr, mem_wdata, mem_wen, mem_wmask}, 69'b0);
    #1 rst = 1'b0;
    @(posedge clk); #2;
    chk("rstmid_late_resp", ctl_now(), 6'b0);
    mem_resp_valid = 1'b0; ifu_req_valid = 1'b1; mem_req_ready = 1'b1;
    #3 chk("rstmid_ifu_ready", ctl_now(), 6'b100000);
    @(posedge clk); #2 ifu_req_valid = 1'b0;
    #3 chk("rstmid_ifu_req", {mem_req_valid, mem_addr, mem_wmask}, {1'b1, 32'h8000_0000, 4'hF});
    @(posedge clk); #2 mem_resp_valid = 1'b1; mem_rdata = 32'hABCD_0123;
    #3 chk("rstmid_ifu_resp", {ifu_resp_valid, lsu_resp_valid, ifu_rdata}, {2'b10, 32'hABCD_0123});

    // Starvation guard: both requesters valid continuously, zero-wait memory
    do_reset();
    for (int c = 0; c < 30; c++) begin
      ifu_req_valid = 1; lsu_req_valid = 1; mem_req_ready = 1; mem_resp_valid = 1;
      #3;
      if (ifu_req_ready) grants.push_back(0);
      if (lsu_req_ready) grants.push_back(1);
      @(posedge clk); #2;
    end
    chk("starve_grant_count", grants.size(), 10);
    for (int g = 0; g < 10 && g < grants.size(); g++)
      chk($sformatf("starve_grant%0d", g), grants[g], exp_order[g]);

    // Randomized traffic against the transaction-level model
    do_reset();
    busy = 0; hs = 0; owner_m = 0; streak_m = 0; cd = 0; fld_m = '0; acc_i = 0; acc_l = 0;
    for (int c = 0; c < 400; c++) begin
      if (acc_i) ifu_req_valid = 0;
      if (acc_l) lsu_req_valid = 0;
      if (!ifu_req_valid && $urandom_range(1, 0) == 1) begin
        ifu_req_valid = 1; ifu_addr = $urandom;
      end
      if (!lsu_req_valid && $urandom_range(1, 0) == 1) begin
        lsu_req_valid = 1; lsu_addr = $urandom; lsu_wen = 1'($urandom_range(1, 0));
        lsu_wdata = $urandom; lsu_wmask = 4'($urandom_range(15, 0));
      end
      mem_req_ready = 1'($urandom_range(1, 0));
      resp_now = hs && (cd == 0);
      mem_rdata = $urandom;
      if (resp_now) mem_resp_valid = 1;
      else mem_resp_valid = !hs && ($urandom_range(3, 0) == 0);
      #3;
      exp_i = 0; exp_l = 0;
      if (!busy && (ifu_req_valid || lsu_req_valid)) begin
        if (lsu_req_valid && (!ifu_req_valid || streak_m < MAXS)) exp_l = 1;
        else exp_i = 1;
      end
      chk("rnd_ready", {ifu_req_ready, lsu_req_ready}, {exp_i, exp_l});
      chk("rnd_mem_valid", mem_req_valid, busy && !hs);
      if (busy && !hs) chk("rnd_mem_fields", {mem_addr, mem_wdata, mem_wen, mem_wmask}, fld_m);
      chk("rnd_resp", {ifu_resp_valid, lsu_resp_valid}, {resp_now && !owner_m, resp_now && owner_m});
      if (resp_now) chk("rnd_rdata", owner_m ? lsu_rdata : ifu_rdata, mem_rdata);
      if (busy) chk("rnd_owner", grant_owner, owner_m);
      acc_i = exp_i; acc_l = exp_l;
      if (exp_i || exp_l) begin
        busy = 1; hs = 0; owner_m = exp_l;
        if (exp_i) begin
          fld_m = {ifu_addr, 32'h0, 1'b0, 4'hF};
          streak_m = 0;
        end else begin
          fld_m = {lsu_addr, lsu_wdata, lsu_wen, lsu_wmask};
          if (ifu_req_valid && streak_m < MAXS) streak_m++;
        end
      end else if (busy && !hs && mem_req_ready) begin
        hs = 1; cd = $urandom_range(2, 0);
      end else if (resp_now) begin
        busy = 0; hs = 0;
      end else if (hs) begin
        cd--;
      end
      @(posedge clk); #2;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the core's single memory port between the instruction-fetch requester (IFU) and the load/store requester (LSU).
- Serialises requests, with at most one transaction in flight.
- Default priority goes to LSU; a bounded-streak counter guarantees forward progress for fetch.
- Sits between IFU/LSU and the memory/bus wrapper; the `grant_owner` output is exposed for DPI-C trace.

Parameters:
- `MAX_LSU_STREAK`, default 4: consecutive LSU grants allowed while IFU is waiting. Once reached, IFU wins the next tie. A value of 0 means IFU always wins ties.

Ports:
- `clk` in 1: clock, all state on rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `ifu_req_valid` in 1: fetch request pending.
- `ifu_req_ready` out 1: fetch request accepted this cycle.
- `ifu_addr` in 32: fetch address.
- `ifu_resp_valid` out 1: fetch data valid, one-cycle pulse.
- `ifu_rdata` out 32: fetch data.
- `lsu_req_valid` in 1: load/store request pending.
- `lsu_req_ready` out 1: load/store accepted this cycle.
- `lsu_addr` in 32: data address.
- `lsu_wen` in 1: 1 = store, 0 = load.
- `lsu_wdata` in 32: store data.
- `lsu_wmask` in 4: byte strobes.
- `lsu_resp_valid` out 1: load data / store completion, one-cycle pulse.
- `lsu_rdata` out 32: load data.
- `mem_req_valid` out 1: request to memory.
- `mem_req_ready` in 1: memory accepts request.
- `mem_addr` out 32, `mem_wen` out 1, `mem_wdata` out 32, `mem_wmask` out 4: latched request fields.
- `mem_resp_valid` in 1: memory response / write acknowledge.
- `mem_rdata` in 32: memory read data.
- `grant_owner` out 1: owner of the current transaction, 0 = IFU, 1 = LSU.

Behaviour:
- **Reset** (async, `rst`=1):
  - state = IDLE; `lsu_streak` = 0; `grant_owner` = 0.
  - Latched `addr`/`wen`/`wdata`/`wmask` = 0.
  - All valid/ready outputs = 0.
- **FSM states:** IDLE, REQ, RESP.
- **IDLE:**
  - If any `*_req_valid` is high, select a winner and assert that requester's `*_req_ready` combinationally for exactly this cycle.
  - At the clock edge, latch the winner's fields (IFU: `wen`=0, `wdata`=0, `wmask`=4'hF), set `grant_owner`, go to REQ.
  - If nothing is valid, stay in IDLE with no ready asserted.
- **Winner selection:**
  - Only one valid: that requester wins.
  - Both valid: LSU wins unless `lsu_streak` >= `MAX_LSU_STREAK`, in which case IFU wins.
- **Streak counter:**
  - Increments (saturating at `MAX_LSU_STREAK`) when LSU is granted while `ifu_req_valid`=1.
  - Clears to 0 on any IFU grant.
  - Is unchanged when LSU is granted and IFU is idle.
  - Width is clog2(`MAX_LSU_STREAK`+1), minimum 1.
- **REQ:**
  - `mem_req_valid`=1, driven with the latched fields, held stable until `mem_req_ready`.
  - On `mem_req_valid` && `mem_req_ready`, go to RESP.
  - `mem_resp_valid` is ignored in REQ; memory must respond no earlier than the cycle after the handshake.
- **RESP:**
  - `mem_req_valid`=0.
  - Response routing is combinational: `<owner>_resp_valid` = `mem_resp_valid`, and `<owner>_rdata` = `mem_rdata`.
  - The non-owner's `resp_valid` stays 0. Both `rdata` outputs may mirror `mem_rdata`.
  - On `mem_resp_valid`, return to IDLE. A new grant can occur on the following cycle.
  - Stores also complete via `mem_resp_valid`; `lsu_rdata` is don't-care for stores.
- **Latency** (zero-wait memory):
  - Cycle T: ready pulse.
  - Cycle T+1: `mem_req_valid` (handshake).
  - Cycle T+2: response.
  - Throughput is one transaction per 3 cycles.
- **Requester rules:**
  - `valid` and the request fields must be held until `ready`.
  - The arbiter samples fields only in the IDLE accept cycle.
  - `*_req_ready` is never asserted outside IDLE and never asserted to both requesters together.
- **`mem_resp_valid` outside RESP** is ignored, with no output pulse.
- **Reset mid-transaction:**
  - Immediately returns to IDLE with outputs cleared.
  - The in-flight response is discarded.
  - The requester must re-issue after reset.
- **Address:** passed through unmodified. No alignment check (owned by LSU).

Test Plan:
- **IFU only, zero-wait memory:** `ifu_addr`=0x80000000, `mem_rdata`=0x00000413.
  - Expect `ifu_req_ready` at T, `mem_req_valid`/`mem_addr`=0x80000000/`mem_wmask`=0xF at T+1.
  - Expect `ifu_resp_valid`=1 with `ifu_rdata`=0x00000413 at T+2; `lsu_resp_valid` stays 0.
- **Simultaneous requests, streak 0:** both valid in IDLE.
  - LSU granted first (`grant_owner`=1), `lsu_streak`=1.
  - After the LSU response, IFU is granted next only if LSU deasserts; otherwise LSU wins again.
- **Starvation guard, `MAX_LSU_STREAK`=4:** both valid continuously.
  - Grant order is LSU×4, IFU, LSU×4, IFU.
  - `lsu_streak` reads 4 before each IFU grant and 0 after it.
- **Store with backpressure:** `lsu_wen`=1, `addr`=0x80001000, `wdata`=0xDEADBEEF, `wmask`=0x3.
  - Hold `mem_req_ready`=0 for 3 cycles: `mem_*` fields stay stable and no requester ready is asserted.
  - Then handshake; a `mem_resp_valid` 2 cycles later produces a single `lsu_resp_valid` pulse.
- **Spurious/late response:** pulse `mem_resp_valid` in IDLE and in REQ before the handshake.
  - No `resp_valid` output pulses and the state does not change.
- **Reset mid-RESP:** assert `rst` asynchronously between clock edges while waiting for a response.
  - All outputs go 0 immediately and state = IDLE.
  - A later `mem_resp_valid` produces no pulse; the next IFU request completes normally.
